// File: rtl/uf_pkg.sv
// Shared widths, run-word field offsets, FSM states and the run record
// used by the union-find run encoder and its output register.
package uf_pkg;
   localparam int ROW_SIZE  = 360;
   localparam int COL_SIZE  = 640;
   localparam int ROOT_W    = 18;
   localparam int IDX_W     = 18;
   localparam int LEN_W     = 10;
   localparam int IN_W      = ROOT_W + IDX_W;
   localparam int OUT_W     = 48;
   localparam int LEN_LSB   = 0;
   localparam int START_LSB = LEN_LSB + LEN_W;
   localparam int ROOT_LSB  = START_LSB + IDX_W;

   localparam logic [ROOT_W-1:0] BG_ROOT = 18'h3FFFF;
   localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(COL_SIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic [ROOT_W-1:0] root;
      logic [IDX_W-1:0]  start;
      logic [LEN_W-1:0]  len;
      logic              last;
      logic              fstart;
   } run_t;

   function automatic logic [OUT_W-1:0] pack_run(input run_t r);
      logic [OUT_W-1:0] w;
      w = {OUT_W{1'b0}};
      w[ROOT_LSB +: ROOT_W] = r.root;
      w[START_LSB +: IDX_W] = r.start;
      w[LEN_LSB +: LEN_W]   = r.len;
      return w;
   endfunction
endpackage

// File: rtl/uf_run_encoder_if.sv
// Pixel-in / run-out streaming bundle for the run encoder; slave is the
// encoder's view, master is the view of whatever drives and consumes it.
interface uf_run_encoder_if;
   import uf_pkg::*;

   logic             i_s_valid;
   logic [IN_W-1:0]  i_s_data;
   logic             i_s_fstart;
   logic             i_s_last;
   logic             o_s_ready;
   logic             o_m_valid;
   logic [OUT_W-1:0] o_m_data;
   logic             o_m_fstart;
   logic             o_m_last;
   logic             i_m_ready;

   modport slave (
      input  i_s_valid, i_s_data, i_s_fstart, i_s_last, i_m_ready,
      output o_s_ready, o_m_valid, o_m_data, o_m_fstart, o_m_last
   );

   modport master (
      output i_s_valid, i_s_data, i_s_fstart, i_s_last, i_m_ready,
      input  o_s_ready, o_m_valid, o_m_data, o_m_fstart, o_m_last
   );
endinterface

// File: rtl/uf_run_outreg.sv
// Single-entry run output register: loads a run when free, holds it
// stable until the downstream side takes it.
module uf_run_outreg
   import uf_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  run_t             i_run,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_fstart,
   output logic             o_last,
   output logic             o_free
);
   logic             r_valid;
   logic [OUT_W-1:0] r_data;
   logic             r_fstart;
   logic             r_last;
   logic             w_free;

   assign w_free = !r_valid || i_ready;

   // Output entry: a load is only honoured when the slot is free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_data   <= {OUT_W{1'b0}};
         r_fstart <= 1'b0;
         r_last   <= 1'b0;
      end else if (i_load && w_free) begin
         r_valid  <= 1'b1;
         r_data   <= pack_run(i_run);
         r_fstart <= i_run.fstart;
         r_last   <= i_run.last;
      end else if (i_ready) begin
         r_valid  <= 1'b0;
      end else begin
         r_valid  <= r_valid;
      end
   end

   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_fstart = r_fstart;
   assign o_last   = r_last;
   assign o_free   = w_free;
endmodule

// File: rtl/uf_run_encoder.sv
// Collapses horizontally contiguous same-root pixels into {root, start, len}
// run words, dropping background runs except the row-closing marker.
module uf_run_encoder
   import uf_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   uf_run_encoder_if.slave bus
);
   state_t            r_state, w_state_nxt;
   logic [ROOT_W-1:0] r_acc_root, w_acc_root_nxt;
   logic [IDX_W-1:0]  r_acc_start, w_acc_start_nxt;
   logic [IDX_W-1:0]  r_acc_end, w_acc_end_nxt;
   logic [LEN_W-1:0]  r_acc_len, w_acc_len_nxt;
   logic              r_fstart_pend, w_fstart_pend_nxt;
   logic              r_ready_base;
   logic              w_free, w_accept, w_cont, w_emit, w_load, w_direct;
   logic [ROOT_W-1:0] w_beat_root;
   logic [IDX_W-1:0]  w_beat_idx;
   run_t              w_emit_run;

   assign w_beat_root   = bus.i_s_data[IN_W-1:IDX_W];
   assign w_beat_idx    = bus.i_s_data[IDX_W-1:0];
   assign bus.o_s_ready = r_ready_base && w_free;
   assign w_accept      = bus.i_s_valid && r_ready_base && w_free;
   // Index compare is one bit wider so the last pixel of a frame never wraps to 0.
   assign w_cont = (w_beat_root == r_acc_root)
                && ({1'b0, w_beat_idx} == ({1'b0, r_acc_end} + 19'd1))
                && (r_acc_len < MAX_LEN)
                && !bus.i_s_fstart;

   // Next-state, accumulator update and run emission.
   always_comb begin
      w_state_nxt       = r_state;
      w_acc_root_nxt    = r_acc_root;
      w_acc_start_nxt   = r_acc_start;
      w_acc_end_nxt     = r_acc_end;
      w_acc_len_nxt     = r_acc_len;
      w_emit            = 1'b0;
      w_direct          = 1'b0;
      w_emit_run.root   = r_acc_root;
      w_emit_run.start  = r_acc_start;
      w_emit_run.len    = r_acc_len;
      w_emit_run.last   = 1'b0;
      w_emit_run.fstart = r_fstart_pend;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_acc_root_nxt  = w_beat_root;
               w_acc_start_nxt = w_beat_idx;
               w_acc_end_nxt   = w_beat_idx;
               w_acc_len_nxt   = 10'd1;
               if (bus.i_s_last) begin
                  w_emit            = 1'b1;
                  w_direct          = 1'b1;
                  w_emit_run.root   = w_beat_root;
                  w_emit_run.start  = w_beat_idx;
                  w_emit_run.len    = 10'd1;
                  w_emit_run.last   = 1'b1;
                  w_emit_run.fstart = r_fstart_pend || bus.i_s_fstart;
                  w_state_nxt       = IDLE;
               end else begin
                  w_state_nxt = RUN;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_accept) begin
               if (w_cont) begin
                  if (!bus.i_s_last) begin
                     w_acc_len_nxt = r_acc_len + 10'd1;
                     w_acc_end_nxt = w_beat_idx;
                     w_state_nxt   = RUN;
                  end else begin
                     w_emit          = 1'b1;
                     w_emit_run.len  = r_acc_len + 10'd1;
                     w_emit_run.last = 1'b1;
                     w_state_nxt     = IDLE;
                  end
               end else begin
                  // Old run goes out now; the beat becomes the open (or pending) run.
                  w_emit          = 1'b1;
                  w_acc_root_nxt  = w_beat_root;
                  w_acc_start_nxt = w_beat_idx;
                  w_acc_end_nxt   = w_beat_idx;
                  w_acc_len_nxt   = 10'd1;
                  if (bus.i_s_last) begin
                     w_state_nxt = FLUSH;
                  end else begin
                     w_state_nxt = RUN;
                  end
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
         FLUSH: begin
            if (w_free) begin
               w_emit          = 1'b1;
               w_emit_run.last = 1'b1;
               w_state_nxt     = IDLE;
            end else begin
               w_state_nxt = FLUSH;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_load = w_emit && !((w_emit_run.root == BG_ROOT) && !w_emit_run.last);

      // A frame-start beat that is not itself emitted waits for the next real word.
      if (w_accept && bus.i_s_fstart && !w_direct) begin
         w_fstart_pend_nxt = 1'b1;
      end else if (w_load && w_emit_run.fstart) begin
         w_fstart_pend_nxt = 1'b0;
      end else begin
         w_fstart_pend_nxt = r_fstart_pend;
      end
   end

   // State, accumulator, frame-start flag and registered ready qualifier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_acc_root    <= {ROOT_W{1'b0}};
         r_acc_start   <= {IDX_W{1'b0}};
         r_acc_end     <= {IDX_W{1'b0}};
         r_acc_len     <= {LEN_W{1'b0}};
         r_fstart_pend <= 1'b0;
         r_ready_base  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_acc_root    <= w_acc_root_nxt;
         r_acc_start   <= w_acc_start_nxt;
         r_acc_end     <= w_acc_end_nxt;
         r_acc_len     <= w_acc_len_nxt;
         r_fstart_pend <= w_fstart_pend_nxt;
         r_ready_base  <= (w_state_nxt != FLUSH);
      end
   end

   uf_run_outreg u_outreg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_run    (w_emit_run),
      .i_ready  (bus.i_m_ready),
      .o_valid  (bus.o_m_valid),
      .o_data   (bus.o_m_data),
      .o_fstart (bus.o_m_fstart),
      .o_last   (bus.o_m_last),
      .o_free   (w_free)
   );
endmodule

// File: doc/uf_run_encoder.md
Name: uf_run_encoder

Overview:
- Downstream consumer of the union-find stage.
- Takes the 36-bit per-pixel result stream and collapses horizontally contiguous pixels that share a root into run-length words {root, start_idx, len}.
- Drops background runs, which cuts traffic into the cluster/gradient stage that follows.
- Single clock domain; valid/ready streaming on both sides with fstart/last framing.

Parameters:
- ROW_SIZE, 360, frame rows (informational; sets the index range).
- COL_SIZE, 640, frame columns; the maximum run length.
- BG_ROOT, 18'h3FFFF, root value marking unlabeled/background pixels.
- LEN_W, 10, run-length field width; must satisfy 2^LEN_W > COL_SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_s_valid  in  1  input beat valid
- i_s_data  in  36  [35:18] root id, [17:0] linear pixel index (row*COL_SIZE+col)
- i_s_fstart  in  1  first beat of frame
- i_s_last  in  1  last beat of a row
- o_s_ready  out  1  input ready
- o_m_valid  out  1  output run valid
- o_m_data  out  48  [47:46]=0, [45:28] root, [27:10] start_idx, [9:0] len
- o_m_fstart  out  1  first run of frame
- o_m_last  out  1  run closes a row
- i_m_ready  in  1  downstream ready

Behaviour:
- Reset (async, rst=1): o_m_valid=0, o_m_data=0, o_m_fstart=0, o_m_last=0, o_s_ready=0, FSM=IDLE, accumulator cleared, fstart_pend=0. First cycle after release: o_s_ready=1.
- Storage: one accumulator (acc_root, acc_start, acc_len, acc_end) plus one output register.
- A beat is accepted when i_s_valid && o_s_ready.
- o_s_ready = (state!=FLUSH) && (!o_m_valid || i_m_ready), registered as a function of the next state.
- Output transfer occurs when o_m_valid && i_m_ready. o_m_data, o_m_fstart and o_m_last are held stable while o_m_valid && !i_m_ready.
- FSM states: IDLE (no open run), RUN (run open), FLUSH (two runs to emit).
- IDLE + accept:
  - Open a run: root=data[35:18], start=end=data[17:0], len=1.
  - If last=1 as well: emit it directly, stay in IDLE.
  - Otherwise go to RUN.
- RUN + accept, continue condition = (root==acc_root) && (idx==acc_end+1) && (acc_len<COL_SIZE) && !fstart:
  - Continue && !last: len+1, end=idx, stay in RUN.
  - Continue && last: emit the extended run with last flag, go to IDLE.
  - Break && !last: emit the old run, open a new run from the beat, stay in RUN.
  - Break && last: emit the old run, hold the beat as a single-pixel pending run with its close flag, go to FLUSH.
- FLUSH:
  - o_s_ready=0.
  - Once the output register frees, emit the pending run with o_m_last=1, go to IDLE.
- Emission rules:
  - Runs with root==BG_ROOT are discarded, except a background run carrying the row-end flag. That run is emitted as a marker with root=BG_ROOT, real start and len, o_m_last=1.
  - An accepted i_s_fstart sets fstart_pend. o_m_fstart=1 on the first emitted word after that; fstart_pend clears on its transfer.
  - fstart on a beat while in RUN always breaks the run. The old run belongs to the previous frame, so fstart_pend must not attach to it.
- Latency: a run appears 1 cycle after the beat that closes it, with i_m_ready=1.
- Throughput: 1 beat/cycle except for 1 bubble per FLUSH.
- Arithmetic: acc_end+1 is computed in 18 bits with no wrap; idx 0 following 230399 is a break. len saturates at COL_SIZE, which forces a break.
- Back-pressure: never drop or duplicate a run; ready depends only on the registered output state.

Decomposition:
- Package uf_pkg holds:
  - field widths ROOT_W=18, IDX_W=18, LEN_W;
  - BG_ROOT;
  - the run-word field offsets;
  - FSM state enum {IDLE, RUN, FLUSH};
  - a run struct (root, start, len, last, fstart).
- Sub-module uf_run_outreg: single-entry output register with valid/ready hold logic, reused by later cluster stages.

Test Plan:
- 5 beats, root 7, idx 100..104, last on 104, i_m_ready=1 -> one word {root 7, start 100, len 5}, o_m_last=1, 1 cycle after the idx-104 beat.
- Roots 3,3,BG,BG,9 at idx 0..4, last on idx 4, fstart on idx 0 -> {3,0,2} with fstart=1. The BG run is dropped. Then FLUSH emits {9,4,1} with last=1, and o_s_ready=0 for exactly 1 cycle.
- 641 beats of root 5 in one row (idx 0..640), last at 640 -> {5,0,640}, then {5,640,1} with last.
- i_m_ready=0 for 10 cycles during a stream of 1-pixel runs -> o_s_ready drops, o_m_data stays stable, no run lost; count and order match the model.
- Row fully BG, idx 640..1279, last at 1279 -> single marker {BG,640,640}, last=1.
- rst asserted mid-run (len=37) -> outputs 0 immediately (async). After release, a new frame encodes correctly with no stale run.
